id_ex_stage: RTL

Pipeline register between decode (ID) and execute (EX) of the 5-stage RISC-V core. It captures the two register-file read operands along with the decoded instruction fields. It bypasses a same-cycle write-back into those operands, because the register file writes on the clock edge and its asynchronous read would otherwise return the old value. It also detects load-use hazards and inserts bubbles, and handles branch flush and downstream stall.

---
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands (with write-back bypass) and decoded
// fields, inserts load-use bubbles, and applies branch flush and downstream stall.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CTRLW = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [CTRLW-1:0] id_ctrl,
    input  logic             id_mem_read,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    input  logic             ex_stall,
    output logic             stall_out,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [CTRLW-1:0] ex_ctrl,
    output logic             ex_mem_read,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [CNTW-1:0]  bubble_cnt,
    output logic [CNTW-1:0]  flush_cnt
);

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CTRLW-1:0] ctrl_q, ctrl_d;
    logic             mem_read_q, mem_read_d;
    logic [XLEN-1:0]  op1_q, op1_d, op2_q, op2_d;
    logic [CNTW-1:0]  bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

    logic             lu;
    logic [XLEN-1:0]  op1_n, op2_n;

    // Register file writes on the edge, so a same-cycle write-back must be forwarded.
    always_comb begin
        op1_n = rf_rd1;
        if (id_rs1 == 5'd0)
            op1_n = '0;
        else if (wb_we && wb_rd == id_rs1)
            op1_n = wb_data;
        op2_n = rf_rd2;
        if (id_rs2 == 5'd0)
            op2_n = '0;
        else if (wb_we && wb_rd == id_rs2)
            op2_n = wb_data;
    end

    assign lu = id_valid && valid_q && mem_read_q && (rd_q != 5'd0) &&
                ((id_use_rs1 && rd_q == id_rs1) || (id_use_rs2 && rd_q == id_rs2));

    assign stall_out = ex_stall || (lu && !flush);

    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        ctrl_d       = ctrl_q;
        mem_read_d   = mem_read_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (ex_stall && !flush) begin
            // Held operands keep tracking write-backs so they are current when the stall lifts.
            if (wb_we && wb_rd != 5'd0) begin
                if (wb_rd == rs1_q) op1_d = wb_data;
                if (wb_rd == rs2_q) op2_d = wb_data;
            end
        end else begin
            valid_d    = id_valid && !flush && !lu;
            pc_d       = id_pc;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            ctrl_d     = id_ctrl;
            mem_read_d = id_mem_read;
            op1_d      = op1_n;
            op2_d      = op2_n;
            if (!valid_d) begin
                rd_d       = 5'd0;
                ctrl_d     = '0;
                mem_read_d = 1'b0;
            end
            if (flush && id_valid && flush_cnt_q != '1)
                flush_cnt_d = flush_cnt_q + CNTW'(1);
            if (!flush && lu && bubble_cnt_q != '1)
                bubble_cnt_d = bubble_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            ctrl_q       <= '0;
            mem_read_q   <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            ctrl_q       <= ctrl_d;
            mem_read_q   <= mem_read_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_mem_read = mem_read_q;
    assign ex_op1      = op1_q;
    assign ex_op2      = op2_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
